t_toggle_counter: RTL and testbench



---
 rtl/t_toggle_counter.sv | 109 ++++++++++
 tb/tb_t_toggle_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/t_toggle_counter.sv
// Bank of WIDTH T flip-flops acting as a toggle register or a binary up/down
// counter, with per-bit sync preset/clear/load priority and an optional saturate.

module t_toggle_counter_stage #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pre,
  input  logic clr,
  input  logic load,
  input  logic d,
  input  logic tog,
  output logic q
);
  logic q_q, q_d;

  // Preset beats clear, so pre+clr together still yields a one.
  always_comb begin
    q_d = q_q;
    if (pre)       q_d = 1'b1;
    else if (clr)  q_d = 1'b0;
    else if (load) q_d = d;
    else if (tog)  q_d = ~q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_BIT;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module t_toggle_counter #(
  parameter int                 WIDTH    = 4,
  parameter logic [WIDTH-1:0]   RST_VAL  = '0,
  parameter bit                 SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pre,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);
  typedef enum logic [1:0] {M_TOG = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_HOLD = 2'b11} mode_e;

  mode_e            m;
  logic [WIDTH-1:0] ones_below, zeros_below, tog;
  logic             active, at_max, at_min, wrap_edge, sat_hold;
  logic             wrap_q, wrap_d;

  assign m      = mode_e'(mode);
  assign active = en & ~pre & ~clr & ~load;
  assign at_max = &q;
  assign at_min = ~|q;

  assign tc        = ((m == M_UP) & at_max) | ((m == M_DN) & at_min);
  assign wrap_edge = active & tc;
  assign sat_hold  = SATURATE & wrap_edge;
  assign wrap_d    = wrap_edge & ~SATURATE;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    // Bits strictly below i; empty for bit 0, so bit 0 always toggles when counting.
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - i);

    assign ones_below[i]  = &(q | ~MASK);
    assign zeros_below[i] = ~|(q & MASK);

    always_comb begin
      tog[i] = 1'b0;
      if (active && !sat_hold) begin
        case (m)
          M_TOG:   tog[i] = t[i];
          M_UP:    tog[i] = ones_below[i];
          M_DN:    tog[i] = zeros_below[i];
          default: tog[i] = 1'b0;
        endcase
      end
    end

    t_toggle_counter_stage #(.RST_BIT(RST_VAL[i])) u_stage (
      .clk  (clk),
      .rst  (rst),
      .pre  (pre),
      .clr  (clr),
      .load (load),
      .d    (d[i]),
      .tog  (tog[i]),
      .q    (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
  assign qn   = ~q;
endmodule

// File: tb/tb_t_toggle_counter.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus and are
// compared against an arithmetic reference model each cycle.

module tb_t_toggle_counter;
  localparam int         W    = 4;
  localparam logic [3:0] RV0  = 4'h5;
  localparam logic [3:0] RV1  = 4'hA;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, pre = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] d = '0, t = '0;
  logic [1:0]   mode = 2'b11;

  logic [W-1:0] q0, qn0, q1, qn1;
  logic         tc0, wrap0, tc1, wrap1;

  t_toggle_counter #(.WIDTH(W), .RST_VAL(RV0), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .pre(pre), .clr(clr), .load(load), .d(d),
    .mode(mode), .t(t), .q(q0), .qn(qn0), .tc(tc0), .wrap(wrap0));

  t_toggle_counter #(.WIDTH(W), .RST_VAL(RV1), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .pre(pre), .clr(clr), .load(load), .d(d),
    .mode(mode), .t(t), .q(q1), .qn(qn1), .tc(tc1), .wrap(wrap1));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] q0; logic w0; logic tc0;
    logic [3:0] q1; logic w1; logic tc1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m0_q, m1_q;
  logic       m0_w, m1_w;
  string      cur_tag = "init";

  function automatic logic model_tc(input logic [3:0] qv);
    return (mode == 2'b01 && qv == 4'hF) || (mode == 2'b10 && qv == 4'h0);
  endfunction

  // Next {wrap, q} from the behavioural rules.
  function automatic logic [4:0] model_next(input logic [3:0] qv, input bit sat);
    int  nv;
    bit  at_lim;
    if (pre)  return {1'b0, 4'hF};
    if (clr)  return {1'b0, 4'h0};
    if (load) return {1'b0, d};
    if (!en)  return {1'b0, qv};
    case (mode)
      2'b00: return {1'b0, qv ^ t};
      2'b01: begin
        at_lim = (qv == 4'hF);
        nv = (int'(qv) + 1) % 16;
        if (at_lim && sat) return {1'b0, qv};
        return {at_lim, 4'(nv)};
      end
      2'b10: begin
        at_lim = (qv == 4'h0);
        nv = (int'(qv) + 15) % 16;
        if (at_lim && sat) return {1'b0, qv};
        return {at_lim, 4'(nv)};
      end
      default: return {1'b0, qv};
    endcase
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.tag = cur_tag;
    e.q0 = m0_q; e.w0 = m0_w; e.tc0 = model_tc(m0_q);
    e.q1 = m1_q; e.w1 = m1_w; e.tc1 = model_tc(m1_q);
    sb.push_back(e);
  endfunction

  // Called just after a rising edge: inputs apply, expectation for this cycle
  // is queued, then the model advances on the next edge.
  task automatic step(input logic e_en, input logic e_pre, input logic e_clr,
                      input logic e_load, input logic [3:0] e_d,
                      input logic [1:0] e_mode, input logic [3:0] e_t);
    logic [4:0] n0, n1;
    en = e_en; pre = e_pre; clr = e_clr; load = e_load;
    d = e_d; mode = e_mode; t = e_t;
    push_exp();
    n0 = model_next(m0_q, 1'b0);
    n1 = model_next(m1_q, 1'b1);
    @(posedge clk);
    m0_q = n0[3:0]; m0_w = n0[4];
    m1_q = n1[3:0]; m1_w = n1[4];
    #1;
  endtask

  // Reset asserted between edges; the check lands on the falling edge while rst is high.
  task automatic do_reset();
    rst = 1'b1;
    m0_q = RV0; m0_w = 1'b0;
    m1_q = RV1; m1_w = 1'b0;
    #1;
    push_exp();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string what, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", what, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, " q0"},    q0,           e.q0);
      chk({e.tag, " qn0"},   qn0,          ~e.q0);
      chk({e.tag, " wrap0"}, {3'b0, wrap0}, {3'b0, e.w0});
      chk({e.tag, " tc0"},   {3'b0, tc0},   {3'b0, e.tc0});
      chk({e.tag, " q1"},    q1,           e.q1);
      chk({e.tag, " qn1"},   qn1,          ~e.q1);
      chk({e.tag, " wrap1"}, {3'b0, wrap1}, {3'b0, e.w1});
      chk({e.tag, " tc1"},   {3'b0, tc1},   {3'b0, e.tc1});
    end
  end

  initial begin
    m0_q = RV0; m0_w = 1'b0; m1_q = RV1; m1_w = 1'b0;
    @(posedge clk); #1;

    cur_tag = "reset";
    do_reset();
    cur_tag = "hold";
    repeat (2) step(1, 0, 0, 0, 4'h0, 2'b11, 4'hF);

    cur_tag = "up17";
    step(1, 0, 1, 0, 4'h0, 2'b01, 4'h0);
    repeat (17) step(1, 0, 0, 0, 4'h0, 2'b01, 4'h0);

    cur_tag = "down_sat";
    step(1, 0, 0, 1, 4'h2, 2'b10, 4'h0);
    repeat (4) step(1, 0, 0, 0, 4'h0, 2'b10, 4'h0);

    cur_tag = "toggle";
    step(1, 0, 1, 0, 4'h0, 2'b00, 4'h0);
    repeat (2) step(1, 0, 0, 0, 4'h0, 2'b00, 4'b1010);

    cur_tag = "prio";
    step(1, 1, 1, 1, 4'h3, 2'b01, 4'h0);
    step(1, 0, 1, 0, 4'h3, 2'b01, 4'h0);
    step(0, 0, 0, 1, 4'h3, 2'b01, 4'h0);
    step(0, 0, 0, 0, 4'h0, 2'b11, 4'h0);

    cur_tag = "en_gate";
    step(1, 0, 0, 1, 4'h7, 2'b01, 4'h0);
    step(1, 0, 0, 0, 4'h0, 2'b01, 4'h0);
    step(0, 0, 0, 0, 4'h0, 2'b01, 4'h0);
    step(1, 0, 0, 0, 4'h0, 2'b01, 4'h0);

    cur_tag = "rst_mid";
    step(1, 0, 0, 1, 4'hF, 2'b01, 4'h0);
    en = 1'b1; load = 1'b0; mode = 2'b01;
    do_reset();
    cur_tag = "post_rst";
    repeat (2) step(1, 0, 0, 0, 4'h0, 2'b11, 4'h0);

    cur_tag = "random";
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      step(r[7:1] != 0 ? ($urandom_range(0, 9) != 0) : 1'b0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 14) == 0, 4'($urandom), 2'($urandom), 4'($urandom));
    end
    step(0, 0, 0, 0, 4'h0, 2'b11, 4'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
